pipe_stall_ctrl: RTL and testbench

- Central pipeline controller that drives the 6-bit stall bus sampled by every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB).
- Generates flush and a redirect PC for exceptions.
- Watchdog on memory-stage stalls: a hung bus access becomes a flush to a timeout vector.
- Sits beside the five-stage core; the stall output feeds every stage register.

---
 rtl/pipe_stall_ctrl_pkg.sv | 29 ++
 rtl/pipe_stall_ctrl_watchdog.sv | 71 +++++++
 rtl/pipe_stall_ctrl.sv | 76 +++++++
 tb/tb_pipe_stall_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stall bus layout,
// stall encodings, the ERET exception code and watchdog FSM states.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W = 6;
  localparam int ST_PC   = 0;
  localparam int ST_IF   = 1;
  localparam int ST_ID   = 2;
  localparam int ST_EX   = 3;
  localparam int ST_MEM  = 4;
  localparam int ST_WB   = 5;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    WD_RUN,
    WD_MEMWAIT,
    WD_TOFLUSH
  } wd_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_watchdog.sv
// Memory-stall watchdog: counts consecutive stallreq_mem cycles and emits a
// one-cycle timeout pulse (suppressed when an exception flush coincides).
module pipe_watchdog
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stallreq_mem_i,
  input  logic exc_i,
  output logic timeout_o
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  wd_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WD_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The RUN cycle that first sees stallreq_mem counts as stall cycle 1, so the
  // flush lands after exactly TIMEOUT stalled cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_o = DISABLE;
    unique case (state_q)
      WD_RUN: begin
        if (stallreq_mem_i && !exc_i) begin
          state_d = WD_MEMWAIT;
          cnt_d   = CW'(1);
        end
      end
      WD_MEMWAIT: begin
        if (!stallreq_mem_i) begin
          state_d = WD_RUN;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = WD_TOFLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WD_TOFLUSH: begin
        timeout_o = ~exc_i;
        state_d   = WD_RUN;
        cnt_d     = '0;
      end
      default: begin
        state_d = WD_RUN;
        cnt_d   = '0;
      end
    endcase
    if (exc_i) begin
      state_d = WD_RUN;
      cnt_d   = '0;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall/flush controller for the five-stage core.
// Optional macro STALL_PERF_CNT_EN adds a stalled-cycle counter (stall_cnt_o).
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int          TIMEOUT        = 256,  // must be >= 2
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0040,
  parameter logic [31:0] TIMEOUT_VECTOR = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic [31:0]        excepttype_i,
  input  logic [31:0]        cp0_epc_i,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               timeout_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o
`endif
);

  logic               exc;
  logic               wd_timeout;
  logic               flush_int;
  logic [STALL_W-1:0] stall_int;
  logic [31:0]        pc_int;

  assign exc = (excepttype_i != '0);

  pipe_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk            (clk),
    .rst_n          (rst),
    .stallreq_mem_i (stallreq_mem),
    .exc_i          (exc),
    .timeout_o      (wd_timeout)
  );

  assign flush_int = exc | wd_timeout;

  always_comb begin
    stall_int = STALL_NONE;
    if (flush_int)         stall_int = STALL_NONE;
    else if (stallreq_mem) stall_int = STALL_MEM;
    else if (stallreq_ex)  stall_int = STALL_EX;
    else if (stallreq_id)  stall_int = STALL_ID;

    pc_int = '0;
    if (exc)             pc_int = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    else if (wd_timeout) pc_int = TIMEOUT_VECTOR;
  end

  // Requests and exceptions are combinational, so reset must mask them explicitly.
  assign stall     = rst ? stall_int  : STALL_NONE;
  assign flush     = rst ? flush_int  : DISABLE;
  assign new_pc    = rst ? pc_int     : '0;
  assign timeout_o = rst ? wd_timeout : DISABLE;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = (stall_int[ST_PC] && !flush_int) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;
  localparam int TIMEOUT = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout_o;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: consecutive stalled-mem cycles, timeout owed next cycle, perf count.
  int          memrun;
  bit          pending;
  logic [31:0] perf;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .timeout_o    (timeout_o)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  wire [39:0] obs = {stall, flush, new_pc, timeout_o};

  // Packed {stall[5:0], flush, new_pc[31:0], timeout}
  function automatic logic [39:0] model_out();
    logic        exc, to;
    logic [5:0]  s;
    logic [31:0] pc;
    if (rst !== 1'b1) return '0;
    exc = (excepttype_i != 0);
    to  = pending;
    if (exc || to)         s = 6'b000000;
    else if (stallreq_mem) s = 6'b011111;
    else if (stallreq_ex)  s = 6'b001111;
    else if (stallreq_id)  s = 6'b000111;
    else                   s = 6'b000000;
    if (exc)     pc = (excepttype_i == 32'he) ? cp0_epc_i : 32'h40;
    else if (to) pc = 32'h80;
    else         pc = 32'h0;
    return {s, exc | to, pc, to & ~exc};
  endfunction

  task automatic model_clear();
    memrun  = 0;
    pending = 0;
    perf    = 0;
  endtask

  task automatic adv();
    logic [39:0] e;
    e = model_out();
    if (rst !== 1'b1) model_clear();
    else begin
      if (e[34]) perf = perf + 32'd1;
      if (e[33]) begin
        memrun  = 0;
        pending = 0;
      end else if (stallreq_mem) begin
        memrun++;
        if (memrun >= TIMEOUT) begin
          pending = 1;
          memrun  = 0;
        end
      end else memrun = 0;
    end
  endtask

  task automatic drive(input logic id, input logic ex, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc, input logic r);
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excepttype_i = exc;
    cp0_epc_i    = epc;
    rst          = r;
    if (!r) model_clear();
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    adv();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, (i % 2) ? 32'he : 32'h3, 32'h55, 1'b0);
      @(negedge clk);
      checks++;
      if (obs !== 40'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d: got %h want 0", i, obs);
      end
`ifdef STALL_PERF_CNT_EN
      checks++;
      if (stall_cnt_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_perf: got %h want 0", stall_cnt_o);
      end
`endif
      clk_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (obs !== model_out()) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", obs, model_out());
    end
    clk_cycle();
  endtask

  task automatic test_id_stall();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (stall !== 6'b000111 || flush !== 1'b0 || obs !== model_out()) begin
      errors++;
      $display("FAIL id_stall: got stall %b flush %b want 000111 0", stall, flush);
    end
    clk_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000 || flush !== 1'b0) begin
      errors++;
      $display("FAIL id_release: got stall %b flush %b want 000000 0", stall, flush);
    end
    clk_cycle();
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (stall !== 6'b001111) begin
      errors++;
      $display("FAIL prio_ex: got %b want 001111", stall);
    end
    clk_cycle();
    drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (stall !== 6'b011111 || obs !== model_out()) begin
      errors++;
      $display("FAIL prio_mem: got %b want 011111", stall);
    end
    clk_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    clk_cycle();
  endtask

  task automatic test_timeout();
    int first_flush = -1;
    int nflush = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL timeout_seq cyc %0d: got %h want %h", i, obs, model_out());
      end
      if (flush === 1'b1) begin
        nflush++;
        if (first_flush < 0) begin
          first_flush = i;
          checks++;
          if (new_pc !== 32'h80 || timeout_o !== 1'b1 || stall !== 6'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got pc %h to %b stall %b want 80 1 0", new_pc, timeout_o, stall);
          end
        end
      end
      clk_cycle();
    end
    checks++;
    if (first_flush != 256 || nflush != 1) begin
      errors++;
      $display("FAIL timeout_cycle: got first %0d count %0d want 256 1", first_flush, nflush);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    clk_cycle();
  endtask

  task automatic test_exception();
    drive(1'b0, 1'b1, 1'b0, 32'he, 32'h1234, 1'b1);
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h1234 || stall !== 6'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL exc_eret: got f %b pc %h st %b want 1 1234 0", flush, new_pc, stall);
    end
    clk_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h1, 32'h1234, 1'b1);
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h40 || stall !== 6'b0) begin
      errors++;
      $display("FAIL exc_vec: got f %b pc %h st %b want 1 40 0", flush, new_pc, stall);
    end
    clk_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (obs !== 40'h0) begin
      errors++;
      $display("FAIL exc_idle: got %h want 0", obs);
    end
    clk_cycle();
  endtask

  task automatic test_exc_on_toflush();
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
      clk_cycle();
    end
    drive(1'b0, 1'b0, 1'b1, 32'h7, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h40 || timeout_o !== 1'b0 || obs !== model_out()) begin
      errors++;
      $display("FAIL exc_toflush: got f %b pc %h to %b want 1 40 0", flush, new_pc, timeout_o);
    end
    clk_cycle();
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (stall !== 6'b011111 || flush !== 1'b0) begin
      errors++;
      $display("FAIL exc_toflush_after: got st %b f %b want 011111 0", stall, flush);
    end
    clk_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    clk_cycle();
  endtask

  task automatic test_reset_midwait();
    int first_flush = -1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
      clk_cycle();
    end
    drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    #1;
    checks++;
    if (obs !== 40'h0) begin
      errors++;
      $display("FAIL midwait_reset: got %h want 0", obs);
    end
    clk_cycle();
    clk_cycle();
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
`ifdef STALL_PERF_CNT_EN
      if (i == 0) begin
        checks++;
        if (stall_cnt_o !== 32'h0) begin
          errors++;
          $display("FAIL midwait_perf: got %h want 0", stall_cnt_o);
        end
      end
`endif
      if (flush === 1'b1 && first_flush < 0) first_flush = i;
      clk_cycle();
    end
    checks++;
    if (first_flush != 256) begin
      errors++;
      $display("FAIL midwait_fresh: got first flush %0d want 256", first_flush);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    clk_cycle();
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] e;
      logic        r;
      if (hold > 0) hold--;
      else if ($urandom_range(0, 9) == 0) hold = $urandom_range(1, 300);
      e = 32'h0;
      if ($urandom_range(0, 59) == 0) e = ($urandom_range(0, 1) == 1) ? 32'he : $urandom;
      r = ($urandom_range(0, 499) != 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (hold > 0) ? 1'b1 : 1'($urandom_range(0, 1)),
            e, $urandom, r);
      @(negedge clk);
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", i, obs, model_out());
      end
`ifdef STALL_PERF_CNT_EN
      checks++;
      if (stall_cnt_o !== perf) begin
        errors++;
        $display("FAIL random_perf cyc %0d: got %h want %h", i, stall_cnt_o, perf);
      end
`endif
      clk_cycle();
    end
  endtask

  initial begin
    model_clear();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_id_stall();
    test_priority();
    test_timeout();
    test_exception();
    test_exc_on_toflush();
    test_reset_midwait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
